// File: rtl/instr_fetch_pkg.sv
// Shared types and sizing for the instruction-fetch refill path.
package instr_fetch_pkg;

  typedef enum logic [2:0] {
    IDLE,
    REQ,
    FILL,
    DRAIN,
    WRITE
  } t_refill_state;

  localparam int WORD_COUNT     = 512 / 32;
  localparam int BEAT_CNT_W     = $clog2(WORD_COUNT);
  localparam int BLOCK_OFFSET_W = 6;

endpackage

// File: rtl/refill_block_buffer.sv
// Assembles a cache block from memory beats; beat 0 lands in the lowest word.
module refill_block_buffer
  import instr_fetch_pkg::*;
#(
  parameter int WORD_SIZE = 32
) (
  input  logic                            clk,
  input  logic                            arstn,
  input  logic                            i_beat_we,
  input  logic                            i_cnt_clear,
  input  logic [WORD_SIZE-1:0]            i_beat_data,
  output logic [WORD_SIZE*WORD_COUNT-1:0] o_block,
  output logic [BEAT_CNT_W-1:0]           o_cnt,
  output logic                            o_last
);

  logic [WORD_SIZE*WORD_COUNT-1:0] block_d, block_q;
  logic [BEAT_CNT_W-1:0]           cnt_d, cnt_q;

  always_comb begin
    block_d = block_q;
    cnt_d   = cnt_q;
    if (i_beat_we) begin
      block_d[int'(cnt_q)*WORD_SIZE +: WORD_SIZE] = i_beat_data;
      cnt_d = cnt_q + 1'b1;
    end
    if (i_cnt_clear) begin
      cnt_d = '0;
    end
  end

  always_ff @(posedge clk or negedge arstn) begin
    if (!arstn) begin
      block_q <= '0;
      cnt_q   <= '0;
    end else begin
      block_q <= block_d;
      cnt_q   <= cnt_d;
    end
  end

  assign o_block = block_q;
  assign o_cnt   = cnt_q;
  assign o_last  = (cnt_q == BEAT_CNT_W'(WORD_COUNT - 1));

endmodule

// File: rtl/instr_cache_refill.sv
// Instruction cache miss handler: requests a 16-beat burst, assembles the block
// and writes it into the cache, stalling fetch for the duration.
module instr_cache_refill
  import instr_fetch_pkg::*;
#(
  parameter int WORD_SIZE   = 32,
  parameter int BLOCK_WIDTH = 512,
  parameter int ADDR_WIDTH  = 32
) (
  input  logic                   clk,
  input  logic                   arstn,
  input  logic                   i_fetch_valid,
  input  logic [ADDR_WIDTH-1:0]  i_instr_addr,
  input  logic                   i_hit,
  input  logic                   i_instr_addr_ma,
  input  logic                   i_flush,
  output logic                   o_stall,
  output logic                   o_cache_we,
  output logic [BLOCK_WIDTH-1:0] o_cache_block,
  output logic                   o_mem_req_valid,
  input  logic                   i_mem_req_ready,
  output logic [ADDR_WIDTH-1:0]  o_mem_addr,
  input  logic                   i_mem_rvalid,
  input  logic [WORD_SIZE-1:0]   i_mem_rdata,
  input  logic                   i_mem_rerr,
  output logic                   o_fetch_fault
);

  t_refill_state         state_d, state_q;
  logic                  req_valid_d, req_valid_q;
  logic [ADDR_WIDTH-1:0] addr_d, addr_q;
  logic                  we_d, we_q;
  logic                  fault_d, fault_q;
  logic                  err_d, err_q;
  logic                  flush_pend_d, flush_pend_q;

  logic                  miss;
  logic                  beat_we;
  logic                  cnt_clear;
  logic [BEAT_CNT_W-1:0] beat_cnt;
  logic                  last_beat;

  assign miss    = i_fetch_valid & ~i_hit & ~i_instr_addr_ma & ~i_flush;
  assign beat_we = i_mem_rvalid & ((state_q == FILL) | (state_q == DRAIN));

  refill_block_buffer #(
    .WORD_SIZE(WORD_SIZE)
  ) u_buffer (
    .clk        (clk),
    .arstn      (arstn),
    .i_beat_we  (beat_we),
    .i_cnt_clear(cnt_clear),
    .i_beat_data(i_mem_rdata),
    .o_block    (o_cache_block),
    .o_cnt      (beat_cnt),
    .o_last     (last_beat)
  );

  // A flush seen while the request is pending is remembered, because the
  // request cannot be retracted and the burst must still be drained.
  always_comb begin
    state_d      = state_q;
    req_valid_d  = req_valid_q;
    addr_d       = addr_q;
    we_d         = 1'b0;
    fault_d      = 1'b0;
    err_d        = err_q;
    flush_pend_d = flush_pend_q;
    cnt_clear    = 1'b0;
    case (state_q)
      IDLE: begin
        if (miss) begin
          addr_d       = {i_instr_addr[ADDR_WIDTH-1:BLOCK_OFFSET_W], {BLOCK_OFFSET_W{1'b0}}};
          req_valid_d  = 1'b1;
          err_d        = 1'b0;
          flush_pend_d = 1'b0;
          state_d      = REQ;
        end
      end
      REQ: begin
        if (i_mem_req_ready) begin
          req_valid_d  = 1'b0;
          cnt_clear    = 1'b1;
          flush_pend_d = 1'b0;
          state_d      = (flush_pend_q | i_flush) ? DRAIN : FILL;
        end else if (i_flush) begin
          flush_pend_d = 1'b1;
        end
      end
      FILL: begin
        if (i_mem_rvalid) begin
          if (i_mem_rerr) begin
            err_d = 1'b1;
          end
          if (last_beat) begin
            if (i_flush) begin
              state_d = IDLE;
            end else if (err_q | i_mem_rerr) begin
              fault_d   = 1'b1;
              cnt_clear = 1'b1;
              state_d   = IDLE;
            end else begin
              we_d    = 1'b1;
              state_d = WRITE;
            end
          end else if (i_flush) begin
            state_d = DRAIN;
          end
        end else if (i_flush) begin
          state_d = DRAIN;
        end
      end
      DRAIN: begin
        if (i_mem_rvalid & last_beat) begin
          cnt_clear = 1'b1;
          state_d   = IDLE;
        end
      end
      WRITE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge arstn) begin
    if (!arstn) begin
      state_q      <= IDLE;
      req_valid_q  <= 1'b0;
      addr_q       <= '0;
      we_q         <= 1'b0;
      fault_q      <= 1'b0;
      err_q        <= 1'b0;
      flush_pend_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      req_valid_q  <= req_valid_d;
      addr_q       <= addr_d;
      we_q         <= we_d;
      fault_q      <= fault_d;
      err_q        <= err_d;
      flush_pend_q <= flush_pend_d;
    end
  end

  // Gated by reset so every output reads 0 the moment reset is asserted.
  assign o_stall         = arstn & ((state_q != IDLE) | miss);
  assign o_mem_req_valid = req_valid_q;
  assign o_mem_addr      = addr_q;
  assign o_cache_we      = we_q;
  assign o_fetch_fault   = fault_q;

endmodule
